f_d_reg: RTL
============

Name: f_d_reg

Overview:
- Fetch/Decode pipeline register of the P7 five-stage MIPS core.
- Sits directly downstream of the PC register and instruction memory. Latches the fetched PC and instruction, and the branch-delay-slot flag, into the Decode stage.
- Detects fetch exceptions (AdEL) and carries the exception code forward to CP0.
- Handles stall, flush and exception/interrupt request (req) so the pipeline redirects cleanly to the handler at 0x0000_4180.

Parameters:
- PC_RESET, 32'h0000_3000, value of pc_d after reset.
- PC_HANDLER, 32'h0000_4180, value of pc_d after a req flush (macroscopic PC of the bubble).
- IM_LO, 32'h0000_3000, lowest legal fetch address.
- IM_HI, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc_f  in  32  PC of the instruction being fetched.
- instr_f  in  32  instruction word read from IM at pc_f.
- bd_f  in  1  fetched instruction sits in a branch delay slot.
- stall  in  1  1 = hold all D-stage state (load-use or md hazard).
- flush  in  1  1 = insert bubble (eret redirect).
- req  in  1  1 = exception/interrupt taken this cycle.
- pc_d  out  32  registered PC.
- instr_d  out  32  registered instruction; 0 (nop) when bubble or exception.
- bd_d  out  1  registered delay-slot flag.
- exc_d  out  5  registered exception code: 0 = none, 4 = AdEL.
- valid_d  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (reset == 0, asynchronous, immediate):
  - pc_d = PC_RESET, instr_d = 0, bd_d = 0, exc_d = 0, valid_d = 0.
  - Release is sampled at the next clk edge.
- Fetch check (combinational on pc_f):
  - adel = (pc_f[1:0] != 0) OR (pc_f < IM_LO) OR (pc_f > IM_HI), unsigned compare.
- Edge update priority: req > flush > stall > load.
- req = 1:
  - pc_d <= PC_HANDLER, instr_d <= 0, bd_d <= 0, exc_d <= 0, valid_d <= 0.
  - Overrides a simultaneous stall; stall is ignored that cycle.
- flush = 1 (req = 0):
  - instr_d <= 0, exc_d <= 0, bd_d <= 0, valid_d <= 0.
  - pc_d <= pc_f, so the bubble carries the redirect-target PC.
- stall = 1 (req = 0, flush = 0):
  - All outputs hold their values, including exc_d and valid_d.
- Load (all controls 0):
  - pc_d <= pc_f, bd_d <= bd_f, valid_d <= 1.
  - If adel: instr_d <= 0, exc_d <= 5'd4.
  - Otherwise: instr_d <= instr_f, exc_d <= 0.
- Latency: exactly one cycle from pc_f/instr_f to the D outputs.
- No combinational path from any input to any output.
- Boundaries:
  - pc_f = IM_HI is legal.
  - pc_f = IM_HI + 4 raises AdEL.
  - pc_f = 32'hFFFF_FFFC raises AdEL (no wrap-around).
  - A misaligned PC inside the range raises AdEL.
- A stall held for any number of cycles preserves state, and the next load proceeds normally.

Optional Feature:
- Macro: F_D_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (32 bits), which increments on every edge where stall = 1 and req = 0.
  - Wraps from 32'hFFFF_FFFF to 0.
  - Cleared by reset; not cleared by flush or req.
- When undefined:
  - The port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset = 0 mid-operation with pc_f = 32'h3010 -> outputs immediately become pc_d = 32'h3000, instr_d = 0, valid_d = 0, exc_d = 0.
- Normal load: pc_f = 32'h3004, instr_f = 32'h3C01_1234, bd_f = 1 -> next edge gives pc_d = 32'h3004, instr_d = 32'h3C01_1234, bd_d = 1, valid_d = 1, exc_d = 0.
- AdEL:
  - pc_f = 32'h3002 -> exc_d = 4, instr_d = 0, valid_d = 1.
  - pc_f = 32'h7000 -> exc_d = 4.
  - pc_f = 32'h6FFC -> exc_d = 0.
- Stall: load pc_f = 32'h3008, then stall = 1 for 3 edges while pc_f changes to 32'h300C -> pc_d stays 32'h3008 throughout. With F_D_STALL_CNT_EN, stall_cnt = 3.
- req during stall: stall = 1 and req = 1 on the same edge -> pc_d = 32'h4180, instr_d = 0, valid_d = 0, bd_d = 0.
- Flush: flush = 1 with pc_f = 32'h3020, instr_f = 32'h0000_0020 -> pc_d = 32'h3020, instr_d = 0, valid_d = 0.

Source files
------------

// File: rtl/f_d_reg.sv
// Fetch/Decode pipeline register: latches PC, instruction and delay-slot flag and flags AdEL.
// Optional stall counter output is enabled by defining F_D_STALL_CNT_EN.
module f_d_reg #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] PC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_f,
  input  logic [31:0] instr_f,
  input  logic        bd_f,
  input  logic        stall,
  input  logic        flush,
  input  logic        req,
  output logic [31:0] pc_d,
  output logic [31:0] instr_d,
  output logic        bd_d,
  output logic [4:0]  exc_d,
  output logic        valid_d
`ifdef F_D_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] st_pc_q,    st_pc_d;
  logic [31:0] st_instr_q, st_instr_d;
  logic        st_bd_q,    st_bd_d;
  logic [4:0]  st_exc_q,   st_exc_d;
  logic        st_valid_q, st_valid_d;
  logic        adel_s;

  // Fetch address check: misaligned or outside instruction memory (unsigned, no wrap).
  always_comb begin
    adel_s = (pc_f[1:0] != 2'b00) || (pc_f < IM_LO) || (pc_f > IM_HI);
  end

  // Next-state selection with priority req > flush > stall > load.
  always_comb begin
    st_pc_d    = st_pc_q;
    st_instr_d = st_instr_q;
    st_bd_d    = st_bd_q;
    st_exc_d   = st_exc_q;
    st_valid_d = st_valid_q;
    if (req) begin
      st_pc_d    = PC_HANDLER;
      st_instr_d = 32'h0000_0000;
      st_bd_d    = 1'b0;
      st_exc_d   = EXC_NONE;
      st_valid_d = 1'b0;
    end else if (flush) begin
      // The bubble still carries the redirect target so CP0 sees a sensible PC.
      st_pc_d    = pc_f;
      st_instr_d = 32'h0000_0000;
      st_bd_d    = 1'b0;
      st_exc_d   = EXC_NONE;
      st_valid_d = 1'b0;
    end else if (stall) begin
      st_pc_d    = st_pc_q;
      st_instr_d = st_instr_q;
      st_bd_d    = st_bd_q;
      st_exc_d   = st_exc_q;
      st_valid_d = st_valid_q;
    end else begin
      st_pc_d    = pc_f;
      st_bd_d    = bd_f;
      st_valid_d = 1'b1;
      if (adel_s) begin
        st_instr_d = 32'h0000_0000;
        st_exc_d   = EXC_ADEL;
      end else begin
        st_instr_d = instr_f;
        st_exc_d   = EXC_NONE;
      end
    end
  end

  // D-stage state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_pc_q    <= PC_RESET;
      st_instr_q <= 32'h0000_0000;
      st_bd_q    <= 1'b0;
      st_exc_q   <= EXC_NONE;
      st_valid_q <= 1'b0;
    end else begin
      st_pc_q    <= st_pc_d;
      st_instr_q <= st_instr_d;
      st_bd_q    <= st_bd_d;
      st_exc_q   <= st_exc_d;
      st_valid_q <= st_valid_d;
    end
  end

  assign pc_d    = st_pc_q;
  assign instr_d = st_instr_q;
  assign bd_d    = st_bd_q;
  assign exc_d   = st_exc_q;
  assign valid_d = st_valid_q;

`ifdef F_D_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counts stalled edges; a req overrides the stall and is not counted. Wraps naturally.
  always_comb begin
    if (stall && !req) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
